multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Control FSM that sequences the shared MIPS datapath as a multicycle machine: fetch, decode, execute, memory, writeback.
//  Drives the datapath mux selects, ALU function and register/PC/IR write enables.
//  Talks to a single unified instruction/data memory through a req/ready handshake with a timeout.
//  Supported instructions: R-type (add/sub/and/or/slt), lw, sw, beq, addi, j.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory request waits for mem_ready before abort (>=1)
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  opcode       in   6  instr[31:26] from IR
//  funct        in   6  instr[5:0] from IR
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes current read/write this cycle
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  iord         out  1  memory address: 0=PC, 1=ALUOut
//  ir_write     out  1  load IR from read data
//  pc_en        out  1  load PC (pc_write | (branch & zero))
//  pc_src       out  2  00=ALU result, 01=ALUOut (branch), 10=jump target
//  reg_dst      out  1  1=rd, 0=rt
//  mem_to_reg   out  1  1=MDR, 0=ALUOut
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  0=PC, 1=reg A
//  alu_src_b    out  2  00=reg B, 01=const 4, 10=imm_ext, 11=imm_ext<<2
//  alucontrol   out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal_op   out  1  one-cycle pulse on undefined opcode/funct
//  mem_error    out  1  one-cycle pulse on memory timeout
// BEHAVIOUR
//  - Moore FSM; outputs decoded from state (plus mem_ready/zero where noted). While rst=0: state=FETCH, wait counter=0, every output 0.
//  - States and transitions:
//      FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, add. On mem_ready: ir_write=1, pc_en=1, pc_src=00, go to DECODE. Otherwise stay.
//      DECODE: alu_src_a=0, alu_src_b=11, add (branch target). Go to MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi) or JUMP (j). Any other opcode: illegal_op=1, go to FETCH.
//      MEMADR: alu_src_a=1, alu_src_b=10, add. Go to MEMRD (lw) or MEMWR (sw).
//      MEMRD: mem_read=1, iord=1. On mem_ready go to MEMWB.
//      MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
//      MEMWR: mem_write=1, iord=1. On mem_ready go to FETCH.
//      EXEC: alu_src_a=1, alu_src_b=00, alucontrol from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt). Go to ALUWB. Undefined funct: illegal_op=1, go to FETCH.
//      ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
//      BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero. Go to FETCH.
//      ADDIEX: alu_src_a=1, alu_src_b=10, add. Go to ADDIWB.
//      ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
//      JUMP: pc_src=10, pc_en=1. Go to FETCH.
//  - CPI: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, each with zero wait states. Every memory wait cycle adds 1.
//  - Handshake: mem_read/mem_write are held steady until mem_ready. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  - Timeout: the wait counter clears on entry to a memory state and increments each cycle without mem_ready. When it reaches MEM_TIMEOUT with no ready:
//      pulse mem_error, go to FETCH; no ir_write, reg_write or pc_en in that cycle.
//      A FETCH timeout retries the same PC.
//  - mem_ready in the timeout cycle itself: the access completes, and mem_error is not raised.
//  - Async reset mid-instruction: immediate return to FETCH, partial writes are abandoned. PC reset is owned by the datapath.
//  - Unused output fields default to 0 in every state (alucontrol default 010).
// STRUCTURE
//  - Shared header mips_defs.vh: opcode/funct constants, alucontrol codes, state encodings (4-bit), alu_src_b/pc_src codes.
//  - Sub-module alu_decoder (combinational): alu_op[1:0], funct -> alucontrol, illegal_funct.
//  - Top level: state register, wait counter, next-state and output decode.
// TESTING
//  1. Reset low 3 cycles, then high; mem_ready=1; opcode=0 funct=0x20 -> all outputs 0 during reset; FETCH,DECODE,EXEC,ALUWB; reg_write=1 and reg_dst=1 in cycle 4; alucontrol=010 in EXEC.
//  2. lw (0x23) with mem_ready low 2 cycles in MEMRD -> mem_read held 3 cycles, iord=1, MEMWB with mem_to_reg=1; 7 cycles total.
//  3. beq (0x04) with zero=1, then zero=0 -> BRANCH has pc_en=1 pc_src=01 alucontrol=110 in the first case, pc_en=0 in the second; back to FETCH.
//  4. j (0x02) -> JUMP has pc_en=1 pc_src=10; sw (0x2B) -> MEMWR mem_write=1; each takes 3 and 4 cycles respectively.
//  5. mem_ready held 0 in FETCH, MEM_TIMEOUT=16 -> mem_error pulse after 16 wait cycles, no ir_write/pc_en, fetch retried; mem_ready=1 exactly at cycle 16 -> normal completion, no mem_error.
//  6. opcode=0x3F, then R-type funct=0x3F -> illegal_op 1-cycle pulse in DECODE and EXEC respectively, no reg_write, return to FETCH; rst dropped during MEMWR -> outputs 0 immediately, FETCH on release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, functs,
// ALU control codes, mux select codes and the FSM state encoding.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's coarse alu_op plus the R-type funct field to
// the 3-bit ALU control; flags functs the datapath cannot execute.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal_funct
);

  // funct only matters for R-type execute; bad functs fall back to add
  always_comb begin
    alucontrol    = ALU_ADD;
    illegal_funct = 1'b0;
    case (alu_op)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: illegal_funct = 1'b1;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath and a unified memory with a req/ready handshake
// guarded by a wait-cycle timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic       mem_error
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  // Last wait cycle allowed; a miss here aborts the access
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    alu_op;
  logic [2:0]    dec_alu;
  logic          illegal_funct;
  logic          pc_write, branch, mem_state, timeout;

  alu_decoder u_alu_dec (
    .alu_op       (alu_op),
    .funct        (funct),
    .alucontrol   (dec_alu),
    .illegal_funct(illegal_funct)
  );

  // State and wait-counter registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and output decode; all outputs forced low while in reset
  always_comb begin
    state_d    = state_q;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    illegal_op = 1'b0;
    mem_error  = 1'b0;

    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // mem_ready in the last allowed cycle still wins over the timeout
    timeout   = mem_state && !mem_ready && (wait_q == WAIT_LAST);
    // Counter only runs while stalled; any state change or retry clears it
    wait_d    = (mem_state && !mem_ready && !timeout) ? wait_q + 1'b1 : '0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          mem_error = 1'b1;   // PC untouched, so the same fetch is retried
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) begin
          mem_error = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) begin
          mem_error = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        if (illegal_funct) begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    pc_en      = pc_write | (branch & zero);
    alucontrol = dec_alu;

    if (!rst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = '0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = '0;
      alucontrol = '0;
      illegal_op = 1'b0;
      mem_error  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every cycle the full output bundle
// is compared with a hand-written expected vector for the intended state.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alucontrol;
  logic       illegal_op, mem_error;

  int nvec = 0;
  int nerr = 0;

  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alucontrol(alucontrol),
    .illegal_op(illegal_op), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  // {mr mw iord irw pc_en} {pc_src} {reg_dst m2r reg_write src_a} {src_b} {alu} {ill merr}
  logic [17:0] outs;
  assign outs = {mem_read, mem_write, iord, ir_write, pc_en, pc_src,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                 alucontrol, illegal_op, mem_error};

  localparam logic [17:0] V_RST    = 18'b00000_00_0000_00_000_00;
  localparam logic [17:0] V_FR     = 18'b10011_00_0000_01_010_00;
  localparam logic [17:0] V_FW     = 18'b10000_00_0000_01_010_00;
  localparam logic [17:0] V_FTO    = 18'b10000_00_0000_01_010_01;
  localparam logic [17:0] V_DEC    = 18'b00000_00_0000_11_010_00;
  localparam logic [17:0] V_DECILL = 18'b00000_00_0000_11_010_10;
  localparam logic [17:0] V_EXADD  = 18'b00000_00_0001_00_010_00;
  localparam logic [17:0] V_EXSUB  = 18'b00000_00_0001_00_110_00;
  localparam logic [17:0] V_EXAND  = 18'b00000_00_0001_00_000_00;
  localparam logic [17:0] V_EXOR   = 18'b00000_00_0001_00_001_00;
  localparam logic [17:0] V_EXSLT  = 18'b00000_00_0001_00_111_00;
  localparam logic [17:0] V_EXILL  = 18'b00000_00_0001_00_010_10;
  localparam logic [17:0] V_ALUWB  = 18'b00000_00_1010_00_010_00;
  localparam logic [17:0] V_MEMADR = 18'b00000_00_0001_10_010_00;
  localparam logic [17:0] V_MEMRD  = 18'b10100_00_0000_00_010_00;
  localparam logic [17:0] V_MEMWB  = 18'b00000_00_0110_00_010_00;
  localparam logic [17:0] V_MEMWR  = 18'b01100_00_0000_00_010_00;
  localparam logic [17:0] V_BRT    = 18'b00001_01_0001_00_110_00;
  localparam logic [17:0] V_BRN    = 18'b00000_01_0001_00_110_00;
  localparam logic [17:0] V_JUMP   = 18'b00001_10_0000_00_010_00;
  localparam logic [17:0] V_ADDIEX = 18'b00000_00_0001_10_010_00;
  localparam logic [17:0] V_ADDIWB = 18'b00000_00_0010_00_010_00;

  task automatic test_reset();
    mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (outs !== V_RST) begin nerr++; $display("FAIL reset cyc %0d: got %b want %b", i, outs, V_RST); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [17:0] ev [4];
      ev = '{V_FR, V_DEC, V_EXADD, V_ALUWB};
      @(negedge clk);
      nvec++;
      if (outs !== ev[i]) begin nerr++; $display("FAIL rtype_add step %0d: got %b want %b", i, outs, ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    opcode = 6'h02;
    // 16 stalled fetch cycles: the 16th aborts with mem_error
    for (int i = 0; i < 16; i++) begin
      logic [17:0] ev;
      ev = (i == 15) ? V_FTO : V_FW;
      mem_ready = 1'b0;
      @(negedge clk);
      nvec++;
      if (outs !== ev) begin nerr++; $display("FAIL fetch_timeout cyc %0d: got %b want %b", i, outs, ev); end
      @(posedge clk); #1;
    end
    // retry of the same fetch, ready arriving exactly in the 16th cycle
    for (int i = 0; i < 18; i++) begin
      logic [17:0] ev;
      ev = (i < 15) ? V_FW : (i == 15) ? V_FR : (i == 16) ? V_DEC : V_JUMP;
      mem_ready = (i >= 15);
      @(negedge clk);
      nvec++;
      if (outs !== ev) begin nerr++; $display("FAIL fetch_retry cyc %0d: got %b want %b", i, outs, ev); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [17:0] ev [8];
    logic [0:7]  rdy;
    ev  = '{V_FR, V_DEC, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB, V_FW};
    rdy = 8'b1110_0110;
    opcode = 6'h23;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      nvec++;
      if (outs !== ev[i]) begin nerr++; $display("FAIL lw_wait step %0d: got %b want %b", i, outs, ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [17:0] ev [7];
    logic [0:6]  rdy, zr;
    ev  = '{V_FR, V_DEC, V_BRT, V_FR, V_DEC, V_BRN, V_FW};
    rdy = 7'b1111_110;
    zr  = 7'b0010_000;
    opcode = 6'h04;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      zero = zr[i];
      @(negedge clk);
      nvec++;
      if (outs !== ev[i]) begin nerr++; $display("FAIL beq step %0d: got %b want %b", i, outs, ev[i]); end
      @(posedge clk); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_j_sw_addi();
    logic [17:0] ev [12];
    logic [5:0]  op [12];
    logic [0:11] rdy;
    ev  = '{V_FR, V_DEC, V_JUMP, V_FR, V_DEC, V_MEMADR, V_MEMWR,
            V_FR, V_DEC, V_ADDIEX, V_ADDIWB, V_FW};
    op  = '{6'h02, 6'h02, 6'h02, 6'h2B, 6'h2B, 6'h2B, 6'h2B,
            6'h08, 6'h08, 6'h08, 6'h08, 6'h08};
    rdy = 12'b1111_1111_1110;
    for (int i = 0; i < 12; i++) begin
      mem_ready = rdy[i];
      opcode = op[i];
      @(negedge clk);
      nvec++;
      if (outs !== ev[i]) begin nerr++; $display("FAIL j_sw_addi step %0d: got %b want %b", i, outs, ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  fn [4];
    logic [17:0] ex [4];
    fn = '{6'h22, 6'h24, 6'h25, 6'h2A};
    ex = '{V_EXSUB, V_EXAND, V_EXOR, V_EXSLT};
    opcode = 6'h00;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      funct = fn[k];
      for (int s = 0; s < 4; s++) begin
        logic [17:0] ev;
        ev = (s == 0) ? V_FR : (s == 1) ? V_DEC : (s == 2) ? ex[k] : V_ALUWB;
        @(negedge clk);
        nvec++;
        if (outs !== ev) begin nerr++; $display("FAIL rtype_b2b instr %0d step %0d: got %b want %b", k, s, outs, ev); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal_reset();
    logic [17:0] ev [9];
    logic [5:0]  op [9];
    logic [0:8]  rdy;
    ev  = '{V_FR, V_DECILL, V_FR, V_DEC, V_EXILL, V_FR, V_DEC, V_MEMADR, V_MEMWR};
    op  = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h2B, 6'h2B, 6'h2B, 6'h2B};
    rdy = 9'b1111_1111_0;
    funct = 6'h3F;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      opcode = op[i];
      @(negedge clk);
      nvec++;
      if (outs !== ev[i]) begin nerr++; $display("FAIL illegal step %0d: got %b want %b", i, outs, ev[i]); end
      @(posedge clk); #1;
    end
    // still in MEMWR waiting for ready; drop reset mid-cycle
    rst = 1'b0;
    #1;
    nvec++;
    if (outs !== V_RST) begin nerr++; $display("FAIL rst_memwr immediate: got %b want %b", outs, V_RST); end
    @(negedge clk);
    nvec++;
    if (outs !== V_RST) begin nerr++; $display("FAIL rst_memwr held: got %b want %b", outs, V_RST); end
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (outs !== V_FR) begin nerr++; $display("FAIL rst_release fetch: got %b want %b", outs, V_FR); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lw();
    test_beq();
    test_j_sw_addi();
    test_back_to_back();
    test_illegal_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
